// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT frame controller: state encoding and
// default timing constants.
package sift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_OCT1  = 3'd2,
    ST_OCT2  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } sift_state_t;

  localparam logic [19:0]  SIFT_TIMEOUT_CYC_DEF = 20'd600000;
  localparam logic [7:0]   SIFT_DRAIN_CYC_DEF   = 8'd64;
  localparam int unsigned  SIFT_CNT_W_DEF       = 16;
  localparam int unsigned  SIFT_FEAT_W          = 20;

endpackage

// File: rtl/sift_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sift_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] LP_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  // Clear has priority; increment stops once the counter is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + LP_ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/sift_frame_ctrl.sv
// SIFT frame controller: sequences one frame through octave 1, octave 2 and a
// pipeline drain, counting keypoints and features along the way.
// Optional feature: define SIFT_CTRL_TIMEOUT_EN to enable the per-octave
// timeout timer (TIMEOUT_CYC); without it the octave phases wait forever.
module sift_frame_ctrl
  import sift_pkg::*;
#(
  parameter logic [19:0] TIMEOUT_CYC = SIFT_TIMEOUT_CYC_DEF,
  parameter logic [7:0]  DRAIN_CYC   = SIFT_DRAIN_CYC_DEF,
  parameter int unsigned CNT_W       = SIFT_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   complete1,
  input  logic                   complete2,
  input  logic                   dout_kp,
  input  logic                   out_en,
  output logic                   pipe_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   octave,
  output logic [CNT_W-1:0]       kp_cnt0,
  output logic [CNT_W-1:0]       kp_cnt1,
  output logic [SIFT_FEAT_W-1:0] feat_cnt,
  output logic [2:0]             state
);

  sift_state_t r_state;
  sift_state_t w_state_next;
  logic        r_c1_d;
  logic        r_c2_d;
  logic        r_err;
  logic [7:0]  r_drain_cnt;
  logic        w_c1_rise;
  logic        w_c2_rise;
  logic        w_drain_last;
  logic        w_timeout;
  logic        w_clr;
  logic        w_kp0_en;
  logic        w_kp1_en;
  logic        w_feat_en;

  assign w_c1_rise    = complete1 & ~r_c1_d;
  assign w_c2_rise    = complete2 & ~r_c2_d;
  assign w_drain_last = (r_drain_cnt == (DRAIN_CYC - 8'd1));

`ifdef SIFT_CTRL_TIMEOUT_EN
  logic [19:0] r_timer;

  assign w_timeout = ((r_state == ST_OCT1) || (r_state == ST_OCT2)) &&
                     (r_timer == (TIMEOUT_CYC - 20'd1));

  // Timer restarts on every state change, so each octave phase gets a full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (w_state_next != r_state) begin
      r_timer <= '0;
    end else if ((r_state == ST_OCT1) || (r_state == ST_OCT2)) begin
      r_timer <= r_timer + 20'd1;
    end
  end
`else
  // No timer in this build; the parameter is referenced only so it folds away.
  assign w_timeout = (TIMEOUT_CYC == '0) & 1'b0;
`endif

  // Edge-detect history, sampled every cycle regardless of state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c1_d <= 1'b0;
      r_c2_d <= 1'b0;
    end else begin
      r_c1_d <= complete1;
      r_c2_d <= complete2;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_CLR;
      ST_CLR:   w_state_next = ST_OCT1;
      ST_OCT1: begin
        if (w_c2_rise)      w_state_next = ST_ERR;
        else if (w_c1_rise) w_state_next = ST_OCT2;
        else if (w_timeout) w_state_next = ST_ERR;
      end
      ST_OCT2: begin
        if (w_c2_rise)      w_state_next = ST_DRAIN;
        else if (w_timeout) w_state_next = ST_ERR;
      end
      ST_DRAIN: if (w_drain_last) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      ST_ERR:   w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
    if (abort) w_state_next = ST_IDLE;
  end

  // Status outputs decoded from the current state.
  always_comb begin
    pipe_rst = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    octave   = 1'b0;
    case (r_state)
      ST_CLR:   busy = 1'b1;
      ST_OCT1:  begin pipe_rst = 1'b0; busy = 1'b1; end
      ST_OCT2:  begin pipe_rst = 1'b0; busy = 1'b1; octave = 1'b1; end
      ST_DRAIN: begin pipe_rst = 1'b0; busy = 1'b1; octave = 1'b1; end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Drain length counter, idle at zero outside DRAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drain_cnt <= '0;
    end else if (r_state == ST_DRAIN) begin
      r_drain_cnt <= r_drain_cnt + 8'd1;
    end else begin
      r_drain_cnt <= '0;
    end
  end

  // Sticky error flag: set on entry to ERR, cleared only by CLR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (r_state == ST_CLR) begin
      r_err <= 1'b0;
    end else if (w_state_next == ST_ERR) begin
      r_err <= 1'b1;
    end
  end

  assign err   = r_err;
  assign state = r_state;

  assign w_clr     = (r_state == ST_CLR);
  assign w_kp0_en  = dout_kp & (r_state == ST_OCT1);
  assign w_kp1_en  = dout_kp & ((r_state == ST_OCT2) || (r_state == ST_DRAIN));
  assign w_feat_en = out_en  & ((r_state == ST_OCT1) || (r_state == ST_OCT2) ||
                                (r_state == ST_DRAIN));

  sift_sat_cnt #(.W(CNT_W)) u_kp_cnt0 (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_clr),
    .i_en  (w_kp0_en),
    .o_cnt (kp_cnt0)
  );

  sift_sat_cnt #(.W(CNT_W)) u_kp_cnt1 (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_clr),
    .i_en  (w_kp1_en),
    .o_cnt (kp_cnt1)
  );

  sift_sat_cnt #(.W(SIFT_FEAT_W)) u_feat_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_clr),
    .i_en  (w_feat_en),
    .o_cnt (feat_cnt)
  );

endmodule
